mcu_p1_result_capture: RTL and testbench
========================================

# mcu_p1_result_capture

Downstream capture stage for the Cortex-M0 example MCU. Firmware streams result bytes out on the P1 GPIO pins using a toggle handshake. This block synchronises the pins and assembles the bytes little-endian into 32-bit words. It buffers the words in a FIFO for the testbench or host logic, and flags any word smaller than its predecessor, which catches bubble-sort output that is out of order.

## Interface
- DEPTH, 8: FIFO depth in 32-bit words; power of two, 2..64.
- SYNC_STAGES, 2: synchroniser flops on the pin inputs; 2..3.
- HCLK  in  1  sole clock; all state is on its rising edge.
- HRESET  in  1  asynchronous, active-high reset.
- p1_data  in  8  result byte (P1[7:0]), asynchronous to HCLK.
- p1_strobe  in  1  byte strobe (P1[8]), asynchronous; each toggle offers one byte.
- p1_ack  out  1  acknowledge (drives P1[9] input); toggles once per accepted byte.
- clear  in  1  synchronous clear of FIFO, assembly, counters and error.
- rd_en  in  1  pop the FIFO head.
- rd_data  out  32  FIFO head (show-ahead); 0 when empty.
- empty  out  1  FIFO empty.
- full  out  1  FIFO holds DEPTH words.
- count  out  $clog2(DEPTH)+1  number of words currently held.
- word_count  out  16  total words pushed since reset/clear; saturates at 16'hFFFF.
- sort_error  out  1  sticky: a pushed word was unsigned-less-than the previous pushed word.

## Operation
- Reset values: p1_ack=0, rd_data=0, empty=1, full=0, count=0, word_count=0, sort_error=0, byte index=0, FSM=IDLE.
- p1_strobe and p1_data each pass through SYNC_STAGES flops. The synchronised strobe s_q is registered again as s_prev. A new byte is detected when s_q != s_prev.
- Firmware protocol: hold p1_data stable from before the strobe toggle until p1_ack toggles.
- FSM states: IDLE, STALL.
  - IDLE, new byte, byte index 0..2: latch the synchronised data into assembly bits [8*idx+7:8*idx], increment idx, toggle p1_ack.
  - IDLE, new byte, idx 3, count<DEPTH (pre-edge): push {byte, asm[23:0]}, set idx=0, toggle p1_ack, update word_count and sort_error.
  - IDLE, new byte, idx 3, count==DEPTH: latch the byte and go to STALL; p1_ack is not toggled.
  - STALL: stay until count<DEPTH (pre-edge); then push the held word, toggle p1_ack, set idx=0 and return to IDLE. New strobe toggles seen in STALL are protocol violations and are ignored.
- A pop with rd_en=1 and empty=1 is ignored. When full, a pop and a waiting push in the same cycle do not combine: the pop frees the slot and the push happens the following cycle.
- Sort check: the first word after reset/clear is not compared. Each later push compares unsigned against the last pushed word (a register, not the FIFO head). Equal words are legal.
- clear has priority over every other action in its cycle, including a push or pop. It empties the FIFO, sets idx=0 and FSM=IDLE, and zeroes word_count, sort_error and the compare history. It does not change p1_ack or the synchroniser flops.
- Pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH. count is computed as the difference between write and read pointers, using an extra wrap bit.

## Timing
- A strobe toggle that meets setup at edge n appears on s_q at edge n+SYNC_STAGES-1. It is detected in the following cycle. The byte is latched and p1_ack toggles at edge n+SYNC_STAGES.
- A pushed word is visible on rd_data, with empty deasserted and count incremented, one edge after the push. sort_error and word_count update on the same edge as the push.
- A pop updates rd_data, count and full on the edge where rd_en=1.
- When STALL exits, the push and the p1_ack toggle occur one edge after the pop that made room.
- HRESET asserted mid-word or mid-stall discards the partial word. All outputs return to their reset values immediately, without waiting for a clock edge.

## Test plan
- Send bytes 0x04,0x03,0x02,0x01, then 0x08,0x07,0x06,0x05 -> rd_data=0x01020304 then 0x05060708; word_count=2; sort_error=0; p1_ack toggled 8 times.
- Send words 0x10, then 0x0F -> sort_error=1 at the second push and stays 1; send 0x0F again -> still 1. Pulse clear -> 0, count=0, word_count=0.
- Push DEPTH=8 ascending words with rd_en=0, then send a 9th word -> full=1, FSM in STALL, p1_ack not toggled for the 4th byte. One pop -> the 9th word is pushed on the next edge, count=8, ack toggles.
- rd_en=1 while empty for 5 cycles -> count remains 0, rd_data=0, no pointer corruption. The next push reads back correctly.
- Assert HRESET after 2 bytes of a word -> all outputs return to reset values. A new 4-byte word then assembles from byte 0.
- Write 20 words while popping continuously so the pointers wrap twice -> read order matches write order, word_count=20.

Source files
------------

// File: rtl/mcu_p1_result_capture.sv
// P1 GPIO result capture: synchronises a toggle-handshake byte stream, packs
// bytes little-endian into 32-bit words, buffers them and flags descending words.
module mcu_p1_result_capture #(
  parameter int DEPTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     HCLK,
  input  logic                     HRESET,
  input  logic [7:0]               p1_data,
  input  logic                     p1_strobe,
  output logic                     p1_ack,
  input  logic                     clear,
  input  logic                     rd_en,
  output logic [31:0]              rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic [15:0]              word_count,
  output logic                     sort_error
);

  localparam int PW = $clog2(DEPTH);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    STALL = 1'b1
  } state_t;

  state_t                          state;
  state_t                          state_next;
  logic [SYNC_STAGES-1:0]          strobe_sync;
  logic [SYNC_STAGES-1:0][7:0]     data_sync;
  logic                            s_q;
  logic                            s_prev;
  logic [7:0]                      s_data;
  logic                            new_byte;
  logic [1:0]                      idx;
  logic [31:0]                     asm_word;
  logic                            latch_byte;
  logic                            hold_byte;
  logic                            push_live;
  logic                            push_held;
  logic                            push;
  logic                            pop;
  logic                            ack_toggle;
  logic [31:0]                     push_word;
  logic [31:0]                     mem [DEPTH];
  logic [PW:0]                     wr_ptr;
  logic [PW:0]                     rd_ptr;
  logic [31:0]                     last_word;
  logic                            have_prev;

  assign s_q      = strobe_sync[SYNC_STAGES-1];
  assign s_data   = data_sync[SYNC_STAGES-1];
  assign new_byte = (s_q != s_prev);

  // Pin synchronisers; deliberately untouched by clear
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      strobe_sync <= '0;
      data_sync   <= '0;
      s_prev      <= 1'b0;
    end else begin
      strobe_sync <= {strobe_sync[SYNC_STAGES-2:0], p1_strobe};
      data_sync   <= {data_sync[SYNC_STAGES-2:0], p1_data};
      s_prev      <= s_q;
    end
  end

  // FSM state register
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state <= IDLE;
    end else if (clear) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next state: the 4th byte stalls only when the FIFO has no room
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (new_byte && (idx == 2'd3) && full) begin
          state_next = STALL;
        end else begin
          state_next = IDLE;
        end
      end
      STALL: begin
        if (!full) begin
          state_next = IDLE;
        end else begin
          state_next = STALL;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs; strobe toggles while stalled are protocol violations and dropped
  always_comb begin
    latch_byte = 1'b0;
    hold_byte  = 1'b0;
    push_live  = 1'b0;
    push_held  = 1'b0;
    case (state)
      IDLE: begin
        if (new_byte) begin
          if (idx != 2'd3) begin
            latch_byte = 1'b1;
          end else if (!full) begin
            push_live = 1'b1;
          end else begin
            hold_byte = 1'b1;
          end
        end else begin
          latch_byte = 1'b0;
        end
      end
      STALL: begin
        if (!full) begin
          push_held = 1'b1;
        end else begin
          push_held = 1'b0;
        end
      end
      default: begin
        latch_byte = 1'b0;
      end
    endcase
  end

  assign push       = push_live | push_held;
  assign ack_toggle = latch_byte | push;
  assign push_word  = push_held ? asm_word : {s_data, asm_word[23:0]};
  assign pop        = rd_en & ~empty;

  // Byte assembly; a held 4th byte parks in the top lane until room appears
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      idx      <= 2'd0;
      asm_word <= 32'h0000_0000;
    end else if (clear) begin
      idx      <= 2'd0;
      asm_word <= 32'h0000_0000;
    end else if (latch_byte) begin
      asm_word[{idx, 3'b000} +: 8] <= s_data;
      idx                          <= idx + 2'd1;
    end else if (hold_byte) begin
      asm_word[31:24] <= s_data;
    end else if (push) begin
      idx <= 2'd0;
    end else begin
      idx <= idx;
    end
  end

  // Acknowledge toggle back to firmware
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      p1_ack <= 1'b0;
    end else if (ack_toggle && !clear) begin
      p1_ack <= ~p1_ack;
    end else begin
      p1_ack <= p1_ack;
    end
  end

  // FIFO storage
  always_ff @(posedge HCLK) begin
    if (push && !clear) begin
      mem[wr_ptr[PW-1:0]] <= push_word;
    end
  end

  // FIFO pointers with an extra wrap bit so full and empty differ
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + (PW+1)'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + (PW+1)'(1);
      end
    end
  end

  assign count   = wr_ptr - rd_ptr;
  assign empty   = (count == '0);
  assign full    = (count == (PW+1)'(DEPTH));
  assign rd_data = empty ? 32'h0000_0000 : mem[rd_ptr[PW-1:0]];

  // Word statistics; ordering is judged against the last pushed word, not the head
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      word_count <= 16'h0000;
      sort_error <= 1'b0;
      last_word  <= 32'h0000_0000;
      have_prev  <= 1'b0;
    end else if (clear) begin
      word_count <= 16'h0000;
      sort_error <= 1'b0;
      last_word  <= 32'h0000_0000;
      have_prev  <= 1'b0;
    end else if (push) begin
      if (word_count != 16'hFFFF) begin
        word_count <= word_count + 16'h0001;
      end
      if (have_prev && (push_word < last_word)) begin
        sort_error <= 1'b1;
      end
      last_word <= push_word;
      have_prev <= 1'b1;
    end else begin
      word_count <= word_count;
    end
  end

endmodule

// File: tb/tb_mcu_p1_result_capture.sv
// Self-checking bench for mcu_p1_result_capture against a queue-based model.
module tb_mcu_p1_result_capture;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic [7:0]  p1_data;
  logic        p1_strobe;
  logic        p1_ack;
  logic        clear;
  logic        rd_en;
  logic [31:0] rd_data;
  logic        empty;
  logic        full;
  logic [3:0]  count;
  logic [15:0] word_count;
  logic        sort_error;

  mcu_p1_result_capture #(.DEPTH(8), .SYNC_STAGES(2)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .p1_data(p1_data), .p1_strobe(p1_strobe),
    .p1_ack(p1_ack), .clear(clear), .rd_en(rd_en), .rd_data(rd_data),
    .empty(empty), .full(full), .count(count), .word_count(word_count),
    .sort_error(sort_error)
  );

  always #5 HCLK = ~HCLK;

  int errors = 0;
  int checks = 0;

  // reference model state
  logic [31:0] mq[$];
  logic [7:0]  mbytes[$];
  int          m_wc;
  bit          m_err;
  bit          m_have;
  logic [31:0] m_last;
  logic        ack_last;
  int          ack_count = 0;
  logic [7:0]  cur_byte;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".rd_data"}, rd_data, (mq.size() > 0) ? mq[0] : 32'h0);
    chk({tag, ".count"}, 32'(count), 32'(mq.size()));
    chk({tag, ".empty"}, 32'(empty), 32'(mq.size() == 0));
    chk({tag, ".full"}, 32'(full), 32'(mq.size() == 8));
    chk({tag, ".word_count"}, 32'(word_count), 32'(m_wc));
    chk({tag, ".sort_error"}, 32'(sort_error), 32'(m_err));
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".p1_ack"}, 32'(p1_ack), 32'h0);
    chk({tag, ".rd_data"}, rd_data, 32'h0);
    chk({tag, ".empty"}, 32'(empty), 32'h1);
    chk({tag, ".full"}, 32'(full), 32'h0);
    chk({tag, ".count"}, 32'(count), 32'h0);
    chk({tag, ".word_count"}, 32'(word_count), 32'h0);
    chk({tag, ".sort_error"}, 32'(sort_error), 32'h0);
  endtask

  task automatic model_clear();
    mq.delete();
    mbytes.delete();
    m_wc   = 0;
    m_err  = 1'b0;
    m_have = 1'b0;
    m_last = 32'h0;
  endtask

  task automatic model_push(input logic [31:0] w);
    if (m_have && (w < m_last)) m_err = 1'b1;
    m_last = w;
    m_have = 1'b1;
    if (m_wc < 65535) m_wc++;
    mq.push_back(w);
  endtask

  // one clock: advance the model with pre-edge inputs, then compare everything
  task automatic tick();
    bit pre_rd, pre_clr;
    int pre_sz;
    pre_rd  = rd_en;
    pre_clr = clear;
    pre_sz  = mq.size();
    @(posedge HCLK);
    #1;
    if (pre_clr) begin
      model_clear();
    end else begin
      if (pre_rd && pre_sz > 0) void'(mq.pop_front());
      if (p1_ack !== ack_last) begin
        ack_count++;
        mbytes.push_back(cur_byte);
        if (mbytes.size() == 4) begin
          model_push({mbytes[3], mbytes[2], mbytes[1], mbytes[0]});
          mbytes.delete();
        end
      end
    end
    ack_last = p1_ack;
    check_all("tick");
  endtask

  task automatic send_byte(input logic [7:0] b);
    int start;
    cur_byte  = b;
    p1_data   = b;
    p1_strobe = ~p1_strobe;
    start     = ack_count;
    for (int i = 0; i < 16 && ack_count == start; i++) tick();
    chk("ack_timeout", 32'(ack_count != start), 32'h1);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    logic [31:0] w;
    int a;
    HRESET = 1'b1; p1_data = 8'h00; p1_strobe = 1'b0;
    clear = 1'b0; rd_en = 1'b0; ack_last = 1'b0;
    model_clear();
    #1;
    chk_reset("reset");
    repeat (2) @(posedge HCLK);
    #1;
    HRESET = 1'b0;
    tick();

    // little-endian assembly of two words
    a = ack_count;
    send_byte(8'h04); send_byte(8'h03); send_byte(8'h02); send_byte(8'h01);
    send_byte(8'h08); send_byte(8'h07); send_byte(8'h06); send_byte(8'h05);
    chk("t1.acks", 32'(ack_count - a), 32'd8);
    chk("t1.head0", rd_data, 32'h0102_0304);
    chk("t1.wc", 32'(word_count), 32'd2);
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    chk("t1.head1", rd_data, 32'h0506_0708);

    // sort error is sticky until clear; equal words are legal
    do_clear();
    send_word(32'h10);
    send_word(32'h0F);
    chk("t2.err", 32'(sort_error), 32'h1);
    send_word(32'h0F);
    chk("t2.err_sticky", 32'(sort_error), 32'h1);
    do_clear();
    chk("t2.clr_err", 32'(sort_error), 32'h0);
    chk("t2.clr_cnt", 32'(count), 32'h0);
    chk("t2.clr_wc", 32'(word_count), 32'h0);

    // fill, stall on the 9th word, release with one pop
    w = $urandom_range(0, 1000);
    for (int i = 0; i < 8; i++) begin
      w = w + $urandom_range(1, 1000);
      send_word(w);
    end
    w = w + $urandom_range(1, 1000);
    for (int i = 0; i < 3; i++) send_byte(w[8*i +: 8]);
    cur_byte = w[31:24]; p1_data = w[31:24]; p1_strobe = ~p1_strobe;
    a = ack_count;
    repeat (6) tick();
    chk("t3.no_ack", 32'(ack_count), 32'(a));
    chk("t3.full", 32'(full), 32'h1);
    chk("t3.count8", 32'(count), 32'd8);
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    chk("t3.after_pop", 32'(count), 32'd7);
    chk("t3.no_ack_pop", 32'(ack_count), 32'(a));
    tick();
    chk("t3.ack", 32'(ack_count), 32'(a + 1));
    chk("t3.refill", 32'(count), 32'd8);
    rd_en = 1'b1;
    for (int i = 0; i < 20 && mq.size() > 0; i++) tick();
    rd_en = 1'b0;
    chk("t3.drained", 32'(count), 32'h0);
    chk("t3.sorted", 32'(sort_error), 32'h0);

    // popping an empty FIFO is harmless
    do_clear();
    rd_en = 1'b1;
    repeat (5) tick();
    rd_en = 1'b0;
    chk("t4.count", 32'(count), 32'h0);
    chk("t4.rd_data", rd_data, 32'h0);
    w = $urandom;
    send_word(w);
    chk("t4.readback", rd_data, w);
    chk("t4.count1", 32'(count), 32'd1);

    // asynchronous reset mid-word
    do_clear();
    send_byte(8'hAA); send_byte(8'hBB);
    HRESET = 1'b1; p1_strobe = 1'b0;
    #2;
    chk_reset("t5.reset");
    model_clear();
    ack_last = 1'b0;
    repeat (2) @(posedge HCLK);
    #1;
    HRESET = 1'b0;
    tick();
    w = $urandom;
    send_word(w);
    chk("t5.word", rd_data, w);
    chk("t5.wc", 32'(word_count), 32'd1);

    // continuous popping while streaming 20 words wraps the pointers
    do_clear();
    rd_en = 1'b1;
    for (int i = 0; i < 20; i++) send_word($urandom);
    repeat (4) tick();
    rd_en = 1'b0;
    chk("t6.wc", 32'(word_count), 32'd20);
    chk("t6.empty", 32'(empty), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
